// File: rtl/gray_to_bin_seq.sv
// Bit-serial Gray-to-binary decoder: accepts a word, resolves one bit per clock MSB-first
// (WIDTH cycles), then holds the result until the downstream handshake completes.
module gray_to_bin_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] gray_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] bin_out,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] acc_up;

  // acc_up[i] is the already-resolved bit above i; zero above the MSB
  assign acc_up = {1'b0, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          g_d     = gray_in;
          idx_d   = IW'(WIDTH - 1);
          acc_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        acc_d[idx_q] = g_q[idx_q] ^ acc_up[idx_q];
        idx_d        = idx_q - IW'(1);
        if (idx_q == '0) begin
          bin_d   = acc_d;
          vld_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = vld_q;
  assign bin_out   = bin_q;

endmodule

// File: tb/tb_gray_to_bin_seq.sv
// Directed bench for gray_to_bin_seq: a WIDTH=4 and a WIDTH=8 instance sharing clock,
// reset, gray input bus and out_ready; each has its own in_valid.
module tb_gray_to_bin_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] gray;
  logic       out_ready;
  logic       in_valid4, in_ready4, out_valid4, busy4;
  logic [3:0] bin4;
  logic       in_valid8, in_ready8, out_valid8, busy8;
  logic [7:0] bin8;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  gray_to_bin_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .gray_in(gray[3:0]), .out_valid(out_valid4), .out_ready(out_ready),
    .bin_out(bin4), .busy(busy4)
  );

  gray_to_bin_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .gray_in(gray), .out_valid(out_valid8), .out_ready(out_ready),
    .bin_out(bin8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode: b[w-1]=g[w-1], b[i]=b[i+1]^g[i]
  function automatic logic [7:0] g2b(input int w, input logic [7:0] g);
    logic [7:0] b;
    b = '0;
    b[w-1] = g[w-1];
    for (int i = w - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic sel_vld(input int w);
    return (w == 4) ? out_valid4 : out_valid8;
  endfunction

  function automatic logic [7:0] sel_bin(input int w);
    return (w == 4) ? {4'b0, bin4} : bin8;
  endfunction

  // Present one word, check acceptance, latency and result. On return the DUT is in HOLD
  // (observed at a negedge) with out_ready still low.
  task automatic send(input int w, input logic [7:0] g, input bit scramble, input string tag);
    int lat;
    out_ready = 1'b0;
    gray = g;
    if (w == 4) in_valid4 = 1'b1; else in_valid8 = 1'b1;
    @(negedge clk);
    if (w == 4) in_valid4 = 1'b0; else in_valid8 = 1'b0;
    check({tag, "_busy"}, (w == 4) ? busy4 : busy8, 1'b1);
    if (scramble) gray = ~g;
    lat = 0;
    while (!sel_vld(w) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, w);
    check({tag, "_bin"}, sel_bin(w), g2b(w, g));
  endtask

  // Complete the output handshake with random out_ready, bounded.
  task automatic drain_random(input int w, input string tag);
    int n;
    n = 0;
    while (sel_vld(w) && n < 64) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, sel_vld(w), 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; gray = '0; out_ready = 1'b0; in_valid4 = 1'b0; in_valid8 = 1'b0;

    // 1. Reset
    #2;
    check("rst_out_valid", out_valid4, 1'b0);
    check("rst_bin", bin4, 4'b0000);
    check("rst_busy", busy4, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready4, 1'b1);

    // 2. 0110 -> 0100, held one cycle, then back to IDLE
    send(4, 8'h06, 1'b0, "t2");
    check("t2_in_ready_hold", in_ready4, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    check("t2_out_valid_drop", out_valid4, 1'b0);
    check("t2_in_ready_back", in_ready4, 1'b1);
    check("t2_bin_kept", bin4, 4'b0100);
    out_ready = 1'b0;

    // 3. 1000 -> 1111, 0000 -> 0000, input scrambled during CONV
    send(4, 8'h08, 1'b1, "t3a");
    check("t3a_const", bin4, 4'b1111);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
    send(4, 8'h00, 1'b1, "t3b");
    check("t3b_const", bin4, 4'b0000);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;

    // 4. Backpressure with ignored in_valid pulses
    send(4, 8'h0B, 1'b0, "t4");
    gray = 8'h05;
    for (int i = 0; i < 5; i++) begin
      in_valid4 = i[0];
      @(negedge clk);
      check("t4_hold_vld", out_valid4, 1'b1);
      check("t4_hold_bin", bin4, 4'b1101);
      check("t4_hold_rdy", in_ready4, 1'b0);
    end
    in_valid4 = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t4_released", out_valid4, 1'b0);
    @(negedge clk);
    check("t4_no_queued", busy4, 1'b0);

    // 5. Reset one CONV edge in (idx=2)
    gray = 8'h0E;
    in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    @(negedge clk);
    check("t5_in_conv", busy4, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_busy", busy4, 1'b0);
    check("t5_out_valid", out_valid4, 1'b0);
    check("t5_bin", bin4, 4'b0000);
    check("t5_in_ready", in_ready4, 1'b1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(4, 8'h01, 1'b0, "t5n");
    check("t5n_const", bin4, 4'b0001);
    out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;

    // 6. Exhaustive sweeps with random out_ready
    for (int c = 0; c < 16; c++) begin
      send(4, 8'(c), 1'b0, "x4");
      drain_random(4, "x4");
    end
    for (int c = 0; c < 256; c++) begin
      send(8, 8'(c), 1'b0, "x8");
      drain_random(8, "x8");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
